// File: rtl/fadd_stream_ctrl_if.sv
// Signal bundle between the stream front-end and its surroundings: operand
// input channel, adder issue/result port and result output channel.
interface fadd_stream_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_op;
  logic        add_valid;
  logic [31:0] add_result;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, in_op, add_result, out_ready,
    output in_ready, add_a, add_b, add_op, add_valid, out_valid, out_data
  );

  // Environment side: operand producer, adder and result consumer.
  modport master (
    output in_valid, in_a, in_b, in_op, add_result, out_ready,
    input  in_ready, add_a, add_b, add_op, add_valid, out_valid, out_data
  );
endinterface

// File: rtl/fadd_stream_ctrl.sv
// Ready/valid front-end for a fixed-latency FP adder: issues operand pairs,
// captures results into a credit-protected FIFO and returns them in order.
module fadd_stream_ctrl #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  fadd_stream_ctrl_if.slave   bus,
  output logic [3:0]          inflight
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  logic [31:0]        add_a_q, add_a_d;
  logic [31:0]        add_b_q, add_b_d;
  logic               add_op_q, add_op_d;
  logic               add_valid_q, add_valid_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY:0]   vld_ext;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic issue;
  logic capture;
  logic pop;
  logic credit_ok;

  // Credit covers both results still in the adder and results already buffered,
  // so every capture is guaranteed a free FIFO slot.
  always_comb begin
    credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
  end

  assign bus.in_ready  = rst && credit_ok;
  assign bus.out_valid = rst && (count_q != '0);
  assign bus.out_data  = mem_q[rptr_q];
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_op    = add_op_q;
  assign bus.add_valid = add_valid_q;
  assign inflight      = 4'(inflight_q);

  assign issue   = bus.in_valid && bus.in_ready;
  assign pop     = bus.out_valid && bus.out_ready;
  assign vld_ext = {vld_q, add_valid_q};
  assign capture = vld_ext[LATENCY];

  always_comb begin
    add_valid_d = issue;
    add_a_d     = issue ? bus.in_a  : '0;
    add_b_d     = issue ? bus.in_b  : '0;
    add_op_d    = issue ? bus.in_op : 1'b0;
    vld_d       = vld_ext[LATENCY-1:0];
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, capture})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({capture, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    wptr_d = capture ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop     ? rptr_q + AW'(1) : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_op_q    <= 1'b0;
      add_valid_q <= 1'b0;
      vld_q       <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_op_q    <= add_op_d;
      add_valid_q <= add_valid_d;
      vld_q       <= vld_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wptr_q] <= bus.add_result;
    end
  end

endmodule

// File: tb/tb_fadd_stream_ctrl.sv
// Scoreboard bench for fadd_stream_ctrl with a behavioural fixed-latency adder.
module tb_fadd_stream_ctrl;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] inflight;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         occ = 0;
  bit         stall_rand = 1'b0;

  logic [31:0] exp_q[$];
  int          cap_q[$];
  int          pop_cyc[$];

  fadd_stream_ctrl_if bus();

  fadd_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .inflight (inflight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Integer-valued float helpers (exact for |v| < 2^24).
  function automatic logic [31:0] i2f(input int v);
    logic [31:0] m;
    int p;
    logic s;
    if (v == 0) return '0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    m = m << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int mag;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    mag = int'({1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic op);
    return op ? i2f(f2i(a) - f2i(b)) : i2f(f2i(a) + f2i(b));
  endfunction

  // Fixed-latency adder: operands this cycle appear on add_result LAT cycles later.
  logic [31:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= fadd_model(bus.add_a, bus.add_b, bus.add_op);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.add_result = pipe[LAT-1];

  always @(posedge clk) begin
    if (stall_rand) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: spec-level credit/occupancy model plus in-order result scoreboard.
  always @(negedge clk) begin
    bit cap;
    bit pop;
    if (!rst) begin
      chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      occ = 0;
    end else begin
      chk("in_ready_credit", 32'(bus.in_ready), 32'((cap_q.size() + occ) < DEPTH));
      chk("out_valid_state", 32'(bus.out_valid), 32'(occ != 0));
      chk("inflight", 32'(inflight), 32'(cap_q.size()));
      cap = (cap_q.size() != 0) && (cap_q[0] == cyc);
      pop = bus.out_valid && bus.out_ready;
      if (cap) begin
        void'(cap_q.pop_front());
        checks++;
        if (occ >= int'(DEPTH)) begin
          errors++;
          $display("FAIL capture_when_full: occupancy %0d, required below %0d", occ, DEPTH);
        end
      end
      if (pop) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h, required no output", bus.out_data);
        end else begin
          chk("result", bus.out_data, exp_q.pop_front());
        end
      end
      occ = occ + int'(cap) - int'(pop);
    end
  end

  // Presents one operand pair and holds it until accepted; in_valid stays high.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] req, output int hcyc);
    bit hs;
    int capc;
    int n;
    hs = 1'b0;
    n = 0;
    hcyc = -1;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.in_ready;
      capc = cyc + 1 + LAT;
      @(posedge clk);
      if (hs) begin
        exp_q.push_back(req);
        cap_q.push_back(capc);
        hcyc = capc - 1 - LAT;
      end
      #1;
      n++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no handshake, required one within 200 cycles");
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cap_q.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d results outstanding, required 0", nm, exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int h;
    int prev;
    int cnt;
    int p;
    int a;
    int b;
    logic op;
    idle();
    bus.out_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    chk("out_valid_after_reset", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Single add: 1.0 + 2.0 = 3.0, latency h+6.
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, h);
    idle();
    at_cycle(h + 1);
    chk("add_valid_next", 32'(bus.add_valid), 32'd1);
    chk("add_a_reg", bus.add_a, 32'h3F800000);
    chk("add_b_reg", bus.add_b, 32'h40000000);
    at_cycle(h + 2);
    chk("add_valid_single", 32'(bus.add_valid), 32'd0);
    chk("add_a_idle", bus.add_a, 32'd0);
    at_cycle(h + 5);
    chk("add_early", 32'(bus.out_valid), 32'd0);
    at_cycle(h + 6);
    chk("add_latency", 32'(bus.out_valid), 32'd1);
    chk("add_data", bus.out_data, 32'h40400000);
    at_cycle(h + 7);
    chk("add_one_result", 32'(bus.out_valid), 32'd0);

    // Subtract: 3.0 - 1.0 = 2.0.
    @(posedge clk);
    #1;
    issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, h);
    idle();
    at_cycle(h + 6);
    chk("sub_data", bus.out_data, 32'h40000000);
    chk("sub_valid", 32'(bus.out_valid), 32'd1);
    at_cycle(h + 7);
    chk("sub_popped", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: exactly DEPTH accepted while the consumer stalls.
    bus.out_ready = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) issue(i2f(1 + k), 32'd0, 1'b0, i2f(1 + k), h);
    bus.in_a = i2f(100);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.in_ready) cnt++;
    end
    chk("bp_accept_limit", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    idle();
    bus.out_ready = 1'b1;
    p = cyc;
    at_cycle(p);
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_full_valid", 32'(bus.out_valid), 32'd1);
    at_cycle(p + 1);
    chk("bp_ready_return", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    drain("bp_drain");

    // Streaming: back-to-back issue and one result per cycle.
    pop_cyc.delete();
    prev = -1;
    for (int k = 0; k < 32; k++) begin
      a = int'($urandom_range(0, 6000)) - 3000;
      b = int'($urandom_range(0, 6000)) - 3000;
      op = 1'($urandom_range(0, 1));
      issue(i2f(a), i2f(b), op, i2f(op ? a - b : a + b), h);
      if (k > 0) chk("stream_back_to_back", 32'(h), 32'(prev + 1));
      prev = h;
    end
    idle();
    drain("stream_drain");
    chk("stream_count", 32'(pop_cyc.size()), 32'd32);
    if (pop_cyc.size() == 32) chk("stream_rate", 32'(pop_cyc[31] - pop_cyc[0]), 32'd31);

    // Random consumer stalls over 200 operations.
    stall_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      a = int'($urandom_range(0, 6000)) - 3000;
      b = int'($urandom_range(0, 6000)) - 3000;
      op = 1'($urandom_range(0, 1));
      issue(i2f(a), i2f(b), op, i2f(op ? a - b : a + b), h);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    stall_rand = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain("stall_drain");

    // Reset with three operations in flight: none of them may surface.
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) issue(i2f(10 + k), i2f(5), 1'b0, i2f(15 + k), h);
    idle();
    rst = 1'b0;
    exp_q.delete();
    cap_q.delete();
    pop_cyc.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("reset_discard", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    issue(i2f(7), i2f(9), 1'b1, i2f(-2), h);
    idle();
    drain("post_reset_drain");
    chk("post_reset_count", 32'(pop_cyc.size()), 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
